// File: rtl/fetcher.sv
// Instruction fetch stage: reads one 32-bit word per start pulse.
// Misaligned PCs, bus access faults and bus timeouts come back as exceptions carrying a NOP payload.
module fetcher #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  output logic        completed,
  output logic        busy,
  input  logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] pc_out,
  output logic [31:0] instr_raw,
  output logic        exception,
  output logic [3:0]  cause
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DONE} state_t;

  localparam int unsigned CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          take, mis, fin, fault;

  always_comb begin
    state_d = state;
    take    = 1'b0;
    mis     = 1'b0;
    fin     = 1'b0;
    fault   = 1'b0;
    case (state)
      IDLE: begin
        if (enabled) begin
          if (pc[1:0] == 2'b00) begin
            state_d = WAIT_MEM;
            take    = 1'b1;
          end else begin
            state_d = DONE;
            mis     = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // an ack in the final watchdog cycle still wins over the timeout
        if (mem_ack) begin
          state_d = DONE;
          fin     = 1'b1;
          fault   = mem_err;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          state_d = DONE;
          fin     = 1'b1;
          fault   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      completed <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      pc_out    <= '0;
      instr_raw <= NOP;
      exception <= 1'b0;
      cause     <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      completed <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      mem_req   <= (state_d == WAIT_MEM);
      if (take) begin
        mem_addr <= pc;
        pc_out   <= pc;
        cnt      <= '0;
      end
      if (mis) begin
        pc_out    <= pc;
        instr_raw <= NOP;
        exception <= 1'b1;
        cause     <= 4'd0;
      end
      if (fin) begin
        instr_raw <= fault ? NOP : mem_rdata;
        exception <= fault;
        cause     <= fault ? 4'd1 : 4'd0;
      end
      if (state == WAIT_MEM && !fin && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher (TIMEOUT=4): the driver pushes expected results and a separate monitor checks each completed pulse.
module tb_fetcher;

  localparam int          TMO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic [31:0] pc = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  logic        completed, busy, mem_req, exception;
  logic [31:0] mem_addr, pc_out, instr_raw;
  logic [3:0]  cause;

  fetcher #(.TIMEOUT(TMO), .NOP(NOP)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .completed(completed), .busy(busy),
    .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .pc_out(pc_out), .instr_raw(instr_raw),
    .exception(exception), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          exc;
    logic [3:0]  cause;
    bit          chk_addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: outcome of one fetch from its pc, ack delay (in request cycles) and error flag.
  function automatic exp_t model(input logic [31:0] a, input int dly, input bit err,
                                 input logic [31:0] d);
    exp_t e;
    e.pc = a;
    e.chk_addr = (a[1:0] == 2'b00);
    if (a[1:0] != 2'b00)   begin e.instr = NOP; e.exc = 1; e.cause = 4'd0; end
    else if (dly >= TMO)   begin e.instr = NOP; e.exc = 1; e.cause = 4'd1; end
    else if (err)          begin e.instr = NOP; e.exc = 1; e.cause = 4'd1; end
    else                   begin e.instr = d;   e.exc = 0; e.cause = 4'd0; end
    return e;
  endfunction

  // Monitor: every completed pulse must match the oldest outstanding expectation.
  logic prev_cmp = 1'b0;
  always @(negedge clk) begin
    if (rstn && completed) begin
      check("completed_one_cycle", {31'd0, prev_cmp}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_completed", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pc_out", pc_out, e.pc);
        check("instr_raw", instr_raw, e.instr);
        check("exception", {31'd0, exception}, {31'd0, e.exc});
        check("cause", {28'd0, cause}, {28'd0, e.cause});
        if (e.chk_addr) check("mem_addr", mem_addr, e.pc);
      end
    end
    prev_cmp <= rstn && completed;
  end

  task automatic do_fetch(input logic [31:0] a, input int dly, input bit err,
                          input logic [31:0] d, input bit stray);
    int lat, reqc, exp_lat, exp_req;
    sb.push_back(model(a, dly, err, d));
    if (a[1:0] != 2'b00)  begin exp_lat = 1;       exp_req = 0;       end
    else if (dly >= TMO)  begin exp_lat = TMO + 1; exp_req = TMO;     end
    else                  begin exp_lat = dly + 2; exp_req = dly + 1; end
    @(posedge clk); #1;
    enabled = 1'b1; pc = a; mem_ack = 1'b0;
    @(posedge clk); #1;
    enabled = stray; pc = $urandom;  // ignored outside IDLE
    lat = 1; reqc = 0;
    while (!completed && lat < 20) begin
      if (mem_req) reqc++;
      mem_ack   = mem_req && (reqc - 1 == dly);
      mem_err   = err;
      mem_rdata = d;
      @(posedge clk); #1;
      lat++;
      enabled = 1'b0;
    end
    check("latency", lat, exp_lat);
    check("req_cycles", reqc, exp_req);
    check("mem_req_low_at_done", {31'd0, mem_req}, 32'd0);
    // stray ack and enable during DONE must both be ignored
    mem_ack = stray; mem_err = 1'b0; mem_rdata = $urandom; enabled = stray;
    @(posedge clk); #1;
    mem_ack = 1'b0; enabled = 1'b0;
    check("idle_after_done", {30'd0, busy, mem_req}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_completed", {31'd0, completed}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_instr", instr_raw, NOP);
    check("rst_exc_cause", {27'd0, exception, cause}, 32'd0);
    rstn = 1'b1;

    do_fetch(32'h0000_1004, 2, 0, 32'h00A0_0093, 0);
    do_fetch(32'h0000_0000, 0, 0, 32'h1111_0001, 0);
    do_fetch(32'h0000_0004, 0, 0, 32'h2222_0002, 0);
    do_fetch(32'h0000_0008, 0, 0, 32'h3333_0003, 0);
    do_fetch(32'h0000_2002, 1, 0, 32'hFFFF_FFFF, 0);
    do_fetch(32'h0000_3000, 1, 1, 32'hDEAD_BEEF, 0);
    do_fetch(32'h0000_4000, 100, 0, 32'h5555_5555, 0);
    do_fetch(32'h0000_4004, TMO - 1, 0, 32'h6666_6666, 0);
    do_fetch(32'h0000_4008, TMO - 1, 1, 32'h7777_7777, 1);
    do_fetch(32'h0000_5000, 1, 0, 32'h8888_8888, 1);

    // async reset while waiting on the bus
    @(posedge clk); #1;
    enabled = 1'b1; pc = 32'h0000_0300;
    @(posedge clk); #1;
    enabled = 1'b0;
    check("req_before_reset", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_completed", {31'd0, completed}, 32'd0);
    check("async_rst_instr", instr_raw, NOP);
    #3 rstn = 1'b1;

    do_fetch(32'h0000_0010, 1, 0, 32'h0000_0093, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_fetch(a, $urandom_range(0, TMO + 1), ($urandom_range(0, 3) == 0),
               $urandom, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
